// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback port arbiter.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_REG_W  = 3;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [WB_REG_W-1:0]  addr;
        logic [WB_DATA_W-1:0] data;
        logic                 squash;
    } ret_entry_t;

endpackage

// File: rtl/wb_ret_fifo.sv
// Memory-return FIFO with a parallel squash-match port over all live entries.
// Latency: push visible at head the cycle after it is written.
// Backpressure: caller must not push while full; pop only when not empty.
module wb_ret_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  ret_entry_t                push_dat,
    input  logic                      pop,
    input  logic                      sq_vld,
    input  logic [WB_REG_W-1:0]       sq_addr,
    output ret_entry_t                head,
    output logic                      head2_sq,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ret_entry_t         slot_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [DEPTH-1:0]   ent_vld;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++)
            ent_vld[i] = {1'b0, (PTR_W'(i) - rd_ptr)} < cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (sq_vld && ent_vld[i] && slot_q[i].addr == sq_addr)
                    slot_q[i].squash <= 1'b1;
            if (push) begin
                slot_q[wr_ptr] <= push_dat;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head     = slot_q[rd_ptr];
    assign head2_sq = slot_q[rd_ptr + PTR_W'(1)].squash;
    assign full     = cnt == CNT_W'(DEPTH);
    assign empty    = cnt == '0;
    assign count    = cnt;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and late load returns.
// Latency: grant decided combinationally in cycle N, rf_* registered in N+1.
// Backpressure: mem_ready = !full; pipe_stall asserted for one pop while starved returns are forced.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int REG_W        = WB_REG_W,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [REG_W-1:0]  pipe_reg,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              mem_valid,
    input  logic [REG_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t          state_q, state_nxt;
    logic [AGE_W-1:0]   age_q, age_nxt;
    ret_entry_t         head, push_dat;
    logic               head2_sq, full, empty;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               pipe_gnt, pop, head_wr, bypass, push, head_sq_nxt;

    always_comb begin
        pipe_gnt = 1'b0;
        pop      = 1'b0;
        bypass   = 1'b0;
        if (state_q == FORCE)
            pop = !empty;
        else if (pipe_valid)
            pipe_gnt = 1'b1;
        else if (!empty)
            pop = 1'b1;
        else
            bypass = mem_valid;
    end

    assign pipe_stall = state_q == FORCE;
    assign mem_ready  = !full;
    assign head_wr    = pop && !head.squash;
    assign push       = mem_valid && mem_ready && !bypass;
    // A same-cycle pipeline write to the same register supersedes the incoming return.
    assign push_dat   = '{addr: mem_reg, data: mem_data,
                          squash: pipe_gnt && (mem_reg == pipe_reg)};

    wb_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .sq_vld   (pipe_gnt),
        .sq_addr  (pipe_reg),
        .head     (head),
        .head2_sq (head2_sq),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Force is judged on next-cycle head state: a head squashed this edge must not trigger it.
    always_comb begin
        state_nxt   = state_q;
        count_nxt   = count + CNT_W'(push) - CNT_W'(pop);
        head_sq_nxt = pop ? head2_sq : (head.squash || (pipe_gnt && head.addr == pipe_reg));
        if (pop || empty)
            age_nxt = '0;
        else if (state_q == NORMAL && !head.squash && age_q != AGE_W'(STARVE_LIMIT))
            age_nxt = age_q + AGE_W'(1);
        else
            age_nxt = age_q;
        case (state_q)
            NORMAL: if (count_nxt != '0 && !head_sq_nxt &&
                        (age_nxt == AGE_W'(STARVE_LIMIT) || count_nxt == CNT_W'(DEPTH)))
                        state_nxt = FORCE;
            FORCE:  if (pop) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= NORMAL;
            age_q    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state_q <= state_nxt;
            age_q   <= age_nxt;
            rf_we   <= pipe_gnt || head_wr || bypass;
            if (pipe_gnt) begin
                rf_waddr <= pipe_reg;
                rf_wdata <= pipe_data;
            end else if (head_wr) begin
                rf_waddr <= head.addr;
                rf_wdata <= head.data;
            end else if (bypass) begin
                rf_waddr <= mem_reg;
                rf_wdata <= mem_data;
            end
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback value and late load returns from the memory/cache miss path.
- Pipeline writes normally win. Memory returns that lose arbitration go into a small FIFO.
- A starvation counter forces buffered returns through by stalling the pipeline.
- Buffered returns superseded by a younger pipeline write to the same register are squashed.
- Sits between the writeback stage and the register file.

Parameters:
- DATA_W, 16, register data width
- REG_W, 3, register address width
- DEPTH, 2, memory-return FIFO entries; power of 2, at least 2
- STARVE_LIMIT, 4, cycles a valid FIFO head may lose arbitration before FORCE is entered

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- pipe_valid  in  1  pipeline writeback request this cycle
- pipe_reg  in  REG_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline writeback value
- pipe_stall  out  1  pipeline must hold pipe_* stable; its request is not taken this cycle
- mem_valid  in  1  memory return request
- mem_reg  in  REG_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  memory return accepted when mem_valid && mem_ready
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  REG_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, all squash bits clear, age=0, state=NORMAL.
  - Combinational outputs therefore read pipe_stall=0, mem_ready=1.
  - Reset mid-operation discards buffered entries with no write.
- Latency: the grant is decided combinationally in cycle N; rf_* carry the winner in cycle N+1. If there is no grant, rf_we=0 in N+1 and rf_waddr/rf_wdata hold their values.
- mem_ready = !full, computed from registered count only. It has no dependence on mem_valid.
- Ordering rule (decided): a memory return is always older in program order than any pipeline write in the same or later cycles.
- Grant in NORMAL:
  1. If pipe_valid, grant the pipeline.
  2. Else if the FIFO is non-empty, pop the head. If the head is squashed, discard it with no write; otherwise write it.
  3. Else if mem_valid, bypass: write mem directly, with no enqueue.
- Any accepted memory return that is not bypassed is pushed. Push and pop in the same cycle are legal; count stays unchanged.
- Squash: when the pipeline is granted to register R, every valid FIFO entry targeting R, and a same-cycle pushed entry targeting R, has its squash bit set.
- age counter:
  - Increments each NORMAL cycle in which the FIFO head is valid, unsquashed and not popped.
  - Resets to 0 on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FSM with states NORMAL and FORCE:
  - NORMAL -> FORCE when, next cycle, age would equal STARVE_LIMIT, or the FIFO would be full with an unsquashed head.
  - FORCE: pipe_stall=1 combinationally. The FIFO head is granted (popped and written if unsquashed). No pipeline grant and no bypass; pushes are still allowed if not full.
  - FORCE -> NORMAL after exactly one pop.
- Squashed heads never trigger FORCE. In NORMAL they pop on the next cycle in which the pipeline is not granted.
- pipe_stall=0 in NORMAL.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Write data is passed unmodified; this block does no width conversion.

Decomposition:
- Shared package wb_pkg:
  - state enum (NORMAL, FORCE)
  - default DATA_W, REG_W
  - struct {reg, data, squash} for a FIFO entry
- One sub-module, wb_ret_fifo: DEPTH-entry FIFO with push/pop, full/empty, and a parallel squash-match port (reg in, set squash bits on match).
- The arbitration/FSM and output registers stay in the top level.

Test Plan:
- Bypass: pipe_valid=0, mem_valid=1, mem_reg=3, mem_data=16'hBEEF, FIFO empty -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'hBEEF; no push; mem_ready stays 1.
- Conflict: pipe_valid=1 (reg 2, 16'h0011) with mem_valid=1 (reg 5, 16'h0022), then idle -> cycle+1 writes r2=0011; cycle+2 writes r5=0022.
- Starvation: one entry buffered (r4=16'h1234), pipe_valid held 1 (reg 1) -> after 4 lost cycles pipe_stall=1 for exactly one cycle; the next cycle writes r4=1234, after which pipeline writes resume.
- Full: two returns buffered while the pipeline is continuously valid -> mem_ready=0, third mem_valid held off; FORCE drains one entry; mem_ready returns to 1 the cycle after the pop.
- Squash: buffer r6=16'hAAAA, then pipeline writes r6=16'h5555 -> r6 written only with 5555; the buffered entry pops with rf_we=0; no FORCE occurs.
- Reset mid-operation: two entries buffered in FORCE, rst low for 1 cycle -> rf_we=0 immediately, pipe_stall=0, mem_ready=1, no buffered write ever appears.
